// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the sequential Booth multiplier
//
// Purpose: FSM state encoding, Booth recoding select values and the
// iteration-counter width helper used by booth_step and booth_mult_seq.
// Ports: none (package).

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {Q[0], Qn} pairs that modify the partial remainder; 00 and 11 only shift.
  localparam logic [1:0] SEL_ADD = 2'b01;
  localparam logic [1:0] SEL_SUB = 2'b10;

  // Counter must hold WIDTH+1, the number of Booth steps per operation.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth step (add/sub then arithmetic shift)
//
// Purpose: given the current {A, Q, Qn} and multiplicand M, produce the
// values after one Booth recode/add and a one-bit arithmetic right shift.
// Ports:
//   a      in  WIDTH+2  partial remainder
//   q      in  WIDTH+1  multiplier shift register
//   qn     in  1        bit shifted out of q on the previous step
//   m      in  WIDTH+2  extended multiplicand
//   a_nxt  out WIDTH+2  next partial remainder
//   q_nxt  out WIDTH+1  next multiplier register
//   qn_nxt out 1        next shifted-out bit

module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH:0]   q,
  input  logic             qn,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+1:0] a_nxt,
  output logic [WIDTH:0]   q_nxt,
  output logic             qn_nxt
);

  logic [WIDTH+1:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], qn})
      SEL_ADD: sum = a + m;
      SEL_SUB: sum = a - m;
      default: sum = a;
    endcase
  end

  // Shift {sum, q, qn} right by one, replicating the sign of sum.
  assign a_nxt  = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign q_nxt  = {sum[0], q[WIDTH:1]};
  assign qn_nxt = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with valid/ready handshakes
//
// Purpose: multiplies x by y (signed or unsigned per operation) one Booth
// step per clock; result held in z until the consumer accepts it.
// Ports:
//   clk        in  1        rising-edge clock
//   rst        in  1        asynchronous active-high reset
//   in_valid   in  1        x, y, sgn valid
//   in_ready   out 1        high only in IDLE
//   x          in  WIDTH    multiplicand
//   y          in  WIDTH    multiplier
//   sgn        in  1        1: two's complement operands, 0: unsigned
//   out_valid  out 1        z holds a finished product
//   out_ready  in  1        consumer accepts z
//   z          out 2*WIDTH  product

module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH+1:0] a;
  logic [WIDTH+1:0] m;
  logic [WIDTH:0]   q;
  logic             qn;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] a_step;
  logic [WIDTH:0]   q_step;
  logic             qn_step;
  logic             accept;
  logic             last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (state == RUN) && (cnt == CW'(1));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a      (a),
    .q      (q),
    .qn     (qn),
    .m      (m),
    .a_nxt  (a_step),
    .q_nxt  (q_step),
    .qn_nxt (qn_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a   <= '0;
      m   <= '0;
      q   <= '0;
      qn  <= 1'b0;
      cnt <= '0;
      z   <= '0;
    end else if (accept) begin
      // One extra bit on Q and two on M/A let signed and unsigned operands
      // share the datapath and keep A - M from overflowing.
      m   <= sgn ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
      q   <= {sgn & y[WIDTH-1], y};
      a   <= '0;
      qn  <= 1'b0;
      cnt <= CW'(WIDTH + 1);
    end else if (state == RUN) begin
      a   <= a_step;
      q   <= q_step;
      qn  <= qn_step;
      cnt <= cnt - CW'(1);
      // After WIDTH+1 steps the product sits in the low bits of {A, Q}.
      if (last_step) z <= {a_step[WIDTH-2:0], q_step};
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq (WIDTH=4 and WIDTH=8)

module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        iv4 = 1'b0, or4 = 1'b0, s4 = 1'b0;
  logic        ir4, ov4;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [7:0]  z4;

  logic        iv8 = 1'b0, or8 = 1'b0, s8 = 1'b0;
  logic        ir8, ov8;
  logic [7:0]  x8 = '0, y8 = '0;
  logic [15:0] z8;

  logic [15:0] exp_q[$];

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .x(x4), .y(y4),
    .sgn(s4), .out_valid(ov4), .out_ready(or4), .z(z4)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8),
    .sgn(s8), .out_valid(ov8), .out_ready(or8), .z(z8)
  );

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'h00, a};
    eb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return ea * eb;
  endfunction

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
    int n = 0;
    while (!ir8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir8) begin
      tests++; fails++;
      $display("FAIL send8_in_ready_timeout in_ready=%0b required 1", ir8);
    end
    iv8 = 1'b1; x8 = a; y8 = b; s8 = s;
    @(negedge clk);
    iv8 = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic recv8(input int max_stall, output logic [15:0] got, output bit ok);
    int n = 0;
    while (!ov8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok  = ov8;
    got = z8;
    if (ok) begin
      repeat ($urandom_range(max_stall, 0)) @(negedge clk);
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
    end
  endtask

  task automatic test_reset;
    tests++; if (ir8 !== 1'b1)  begin fails++; $display("FAIL reset_in_ready8 got=%0b required=1", ir8); end
    tests++; if (ov8 !== 1'b0)  begin fails++; $display("FAIL reset_out_valid8 got=%0b required=0", ov8); end
    tests++; if (z8 !== 16'h0)  begin fails++; $display("FAIL reset_z8 got=%h required=0000", z8); end
    tests++; if (ir4 !== 1'b1)  begin fails++; $display("FAIL reset_in_ready4 got=%0b required=1", ir4); end
    tests++; if (ov4 !== 1'b0)  begin fails++; $display("FAIL reset_out_valid4 got=%0b required=0", ov4); end
    tests++; if (z4 !== 8'h0)   begin fails++; $display("FAIL reset_z4 got=%h required=00", z4); end
  endtask

  task automatic test_w4_latency;
    int n = 0;
    @(negedge clk);
    iv4 = 1'b1; x4 = 4'h8; y4 = 4'h7; s4 = 1'b1;
    @(posedge clk);
    #1 iv4 = 1'b0;
    while (!ov4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++; if (n != 5)       begin fails++; $display("FAIL w4_latency got=%0d required=5", n); end
    tests++; if (z4 !== 8'hC8) begin fails++; $display("FAIL w4_product got=%h required=c8", z4); end
    @(negedge clk); or4 = 1'b1;
    @(negedge clk); or4 = 1'b0;
    tests++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
      fails++; $display("FAIL w4_release out_valid=%0b in_ready=%0b required 0/1", ov4, ir4);
    end
  endtask

  task automatic test_directed;
    logic [7:0]  xs[4] = '{8'h80, 8'hFF, 8'hFF, 8'h00};
    logic [7:0]  ys[4] = '{8'h80, 8'h01, 8'hFF, 8'hC8};
    logic        ss[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] es[4] = '{16'h4000, 16'hFFFF, 16'hFE01, 16'h0000};
    logic [15:0] got, e;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      send8(xs[i], ys[i], ss[i], es[i]);
      recv8(2, got, ok);
      e = exp_q.pop_front();
      tests++;
      if (!ok)            begin fails++; $display("FAIL directed_%0d_timeout out_valid never rose", i); end
      else if (got !== e) begin fails++; $display("FAIL directed_%0d got=%h required=%h", i, got, e); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] got, e;
    bit ok;
    int n = 0;
    send8(8'h23, 8'h45, 1'b0, 16'h096F);
    while (!ov8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    tests++; if (!ov8) begin fails++; $display("FAIL bp_timeout out_valid=%0b required 1", ov8); end
    for (int i = 0; i < 10; i++) begin
      iv8 = 1'b1; x8 = 8'($urandom); y8 = 8'($urandom); s8 = 1'($urandom);
      @(negedge clk);
      tests++; if (ov8 !== 1'b1) begin fails++; $display("FAIL bp_out_valid_%0d got=%0b required=1", i, ov8); end
      tests++; if (z8 !== e)     begin fails++; $display("FAIL bp_z_stable_%0d got=%h required=%h", i, z8, e); end
      tests++; if (ir8 !== 1'b0) begin fails++; $display("FAIL bp_in_ready_%0d got=%0b required=0", i, ir8); end
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    send8(8'd7, 8'd9, 1'b0, 16'd63);
    recv8(0, got, ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok)            begin fails++; $display("FAIL bp_next_timeout out_valid never rose"); end
    else if (got !== e) begin fails++; $display("FAIL bp_next_result got=%h required=%h", got, e); end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] got, e;
    bit ok;
    bit seen = 0;
    send8(8'd200, 8'd100, 1'b0, model8(8'd200, 8'd100, 1'b0));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (ov8 !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got=%0b required=0", ov8); end
    tests++; if (z8 !== 16'h0) begin fails++; $display("FAIL rst_mid_z got=%h required=0000", z8); end
    tests++; if (ir8 !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready got=%0b required=1", ir8); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov8) seen = 1;
    end
    tests++; if (seen) begin fails++; $display("FAIL rst_mid_stale out_valid seen=1 required=0"); end
    send8(8'd3, 8'd5, 1'b0, 16'd15);
    recv8(1, got, ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok)            begin fails++; $display("FAIL rst_next_timeout out_valid never rose"); end
    else if (got !== e) begin fails++; $display("FAIL rst_next_result got=%h required=%h", got, e); end
  endtask

  task automatic test_back_to_back;
    int c = 0;
    int hits = 0;
    int t0 = 0, t1 = 0;
    logic [15:0] z_a = '0, z_b = '0;
    @(negedge clk);
    iv8 = 1'b1; x8 = 8'd13; y8 = 8'd11; s8 = 1'b0; or8 = 1'b1;
    while (hits < 2 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (ov8) begin
        if (hits == 0) begin t0 = c; z_a = z8; end
        else           begin t1 = c; z_b = z8; end
        hits++;
      end
    end
    @(negedge clk);
    iv8 = 1'b0;
    repeat (20) @(negedge clk);
    or8 = 1'b0;
    tests++; if (hits != 2) begin fails++; $display("FAIL b2b_results got=%0d required=2", hits); end
    tests++; if (t1 - t0 != 11) begin fails++; $display("FAIL b2b_period got=%0d required=11", t1 - t0); end
    tests++; if (z_a !== 16'd143 || z_b !== 16'd143) begin
      fails++; $display("FAIL b2b_products got=%h,%h required=008f", z_a, z_b);
    end
    tests++; if (ir8 !== 1'b1) begin fails++; $display("FAIL b2b_drain in_ready got=%0b required=1", ir8); end
  endtask

  task automatic test_random;
    logic [7:0]  a, b;
    logic        s;
    logic [15:0] got, e;
    bit ok;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      send8(a, b, s, model8(a, b, s));
      recv8(3, got, ok);
      e = exp_q.pop_front();
      tests++;
      if (!ok)            begin fails++; $display("FAIL random_%0d_timeout out_valid never rose", i); end
      else if (got !== e) begin fails++; $display("FAIL random_%0d x=%h y=%h sgn=%0b got=%h required=%h", i, a, b, s, got, e); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_w4_latency;
    test_directed;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
